// File: rtl/axis_if.sv
// AXI-Stream channel bundle: tvalid/tdata flow manager -> subordinate, tready flows back.
// master = side that drives tvalid/tdata, slave = side that drives tready.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-Stream skid slice: registers tready backward and tvalid/tdata forward.
// Optional saturating stall counter enabled by defining AXIS_SKID_SLICE_PERF_EN.
module axis_skid_slice #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_if.master                 axis_mif,
    axis_if.slave                  axis_sif,
    input  logic                   invalidate
`ifdef AXIS_SKID_SLICE_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
    localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;

    if (TDATA_WIDTH <= 0 || TDATA_WIDTH != axis_sif.TDATA_WIDTH) begin : g_bad_width
        $fatal(1, "axis_skid_slice: TDATA_WIDTH must be >0 and equal on both sides");
    end
    if (STALL_CNT_W < 1) begin : g_bad_cnt_width
        $fatal(1, "axis_skid_slice: STALL_CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } st_t;

    st_t                    st, st_d;
    logic [TDATA_WIDTH-1:0] main_q, main_d;
    logic [TDATA_WIDTH-1:0] skid_q, skid_d;
    logic                   in_hs;
    logic                   out_hs;

    // Valid/ready contract: a beat moves on a port exactly in a cycle where tvalid && tready
    // are both high at the rising edge; tready never depends combinationally on axis_mif.tready.
    assign axis_mif.tvalid = (st != EMPTY);
    assign axis_mif.tdata  = main_q;
    assign axis_sif.tready = !rst && (st != FULL);

    assign in_hs  = axis_sif.tvalid && axis_sif.tready;
    assign out_hs = axis_mif.tvalid && axis_mif.tready;

    always_comb begin
        st_d   = st;
        main_d = main_q;
        skid_d = skid_q;
        if (invalidate) begin
            // Flush: held data registers are left as-is, only occupancy is cleared.
            st_d = EMPTY;
        end else begin
            case (st)
                EMPTY: begin
                    if (in_hs) begin
                        st_d   = BUSY;
                        main_d = axis_sif.tdata;
                    end
                end
                BUSY: begin
                    if (in_hs && !out_hs) begin
                        st_d   = FULL;
                        skid_d = axis_sif.tdata;
                    end else if (in_hs && out_hs) begin
                        main_d = axis_sif.tdata;
                    end else if (out_hs) begin
                        st_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        st_d   = BUSY;
                        main_d = skid_q;
                    end
                end
                default: st_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            st     <= st_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef AXIS_SKID_SLICE_PERF_EN
    // Counts cycles a held beat is refused downstream; survives invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (axis_mif.tvalid && !axis_mif.tready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_skid_slice.sv
// Directed bench for axis_skid_slice: reset, streaming, backpressure, simultaneous in/out,
// invalidate, and (with AXIS_SKID_SLICE_PERF_EN) stall counter saturation.
module tb_axis_skid_slice;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic invalidate;

    axis_if #(.TDATA_WIDTH(W)) m_if ();
    axis_if #(.TDATA_WIDTH(W)) s_if ();

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

`ifdef AXIS_SKID_SLICE_PERF_EN
    logic [3:0] stall_cnt;

    axis_skid_slice #(.STALL_CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .axis_mif   (m_if),
        .axis_sif   (s_if),
        .invalidate (invalidate),
        .stall_cnt  (stall_cnt)
    );
`else
    axis_skid_slice dut (
        .clk        (clk),
        .rst        (rst),
        .axis_mif   (m_if),
        .axis_sif   (s_if),
        .invalidate (invalidate)
    );
`endif

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", {24'd0, m_if.tdata}, 32'hFFFF_FFFF);
            end else begin
                check("sb_data", {24'd0, m_if.tdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        invalidate  = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;

        // Reset: two cycles high
        tick();
        check("rst_mvalid_0", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_sready_0", {31'd0, s_if.tready}, 32'd0);
        tick();
        check("rst_mvalid_1", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_sready_1", {31'd0, s_if.tready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_sready", {31'd0, s_if.tready}, 32'd1);
        check("post_rst_mvalid", {31'd0, m_if.tvalid}, 32'd0);

        // Streaming 0x01..0x10 with downstream always ready
        m_if.tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = W'(i);
            exp_q.push_back(W'(i));
            check("strm_sready", {31'd0, s_if.tready}, 32'd1);
            tick();
            if (i == 1) begin
                check("strm_lat_valid", {31'd0, m_if.tvalid}, 32'd1);
                check("strm_lat_data", {24'd0, m_if.tdata}, 32'h01);
            end
        end
        s_if.tvalid = 1'b0;
        tick();
        check("strm_drained", {31'd0, m_if.tvalid}, 32'd0);
        check("strm_q_empty", exp_q.size(), 32'd0);

        // Backpressure: 0xA, 0xB accepted, 0xC held off
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h0A;
        check("bp_sready_a", {31'd0, s_if.tready}, 32'd1);
        exp_q.push_back(8'h0A);
        tick();
        s_if.tdata = 8'h0B;
        check("bp_sready_b", {31'd0, s_if.tready}, 32'd1);
        exp_q.push_back(8'h0B);
        tick();
        s_if.tdata = 8'h0C;
        check("bp_sready_drop", {31'd0, s_if.tready}, 32'd0);
        check("bp_mvalid", {31'd0, m_if.tvalid}, 32'd1);
        check("bp_hold_a0", {24'd0, m_if.tdata}, 32'h0A);
        tick();
        check("bp_sready_low", {31'd0, s_if.tready}, 32'd0);
        check("bp_hold_a1", {24'd0, m_if.tdata}, 32'h0A);
        tick();
        check("bp_hold_a2", {24'd0, m_if.tdata}, 32'h0A);
        m_if.tready = 1'b1;
        tick();
        check("bp_sready_rise", {31'd0, s_if.tready}, 32'd1);
        check("bp_out_b", {24'd0, m_if.tdata}, 32'h0B);
        exp_q.push_back(8'h0C);
        tick();
        s_if.tvalid = 1'b0;
        check("bp_out_c", {24'd0, m_if.tdata}, 32'h0C);
        tick();
        check("bp_drained", {31'd0, m_if.tvalid}, 32'd0);
        check("bp_q_empty", exp_q.size(), 32'd0);

        // Simultaneous in/out while BUSY
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h05;
        exp_q.push_back(8'h05);
        tick();
        s_if.tdata = 8'h06;
        exp_q.push_back(8'h06);
        check("sim_main_5", {24'd0, m_if.tdata}, 32'h05);
        tick();
        s_if.tvalid = 1'b0;
        check("sim_mvalid", {31'd0, m_if.tvalid}, 32'd1);
        check("sim_main_6", {24'd0, m_if.tdata}, 32'h06);
        check("sim_sready", {31'd0, s_if.tready}, 32'd1);
        tick();
        check("sim_drained", {31'd0, m_if.tvalid}, 32'd0);

        // Invalidate while FULL: 0x1/0x2 must never leave
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h01;
        tick();
        s_if.tdata = 8'h02;
        tick();
        s_if.tvalid = 1'b0;
        check("inv_full_sready", {31'd0, s_if.tready}, 32'd0);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_full_mvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("inv_full_sready_back", {31'd0, s_if.tready}, 32'd1);
        m_if.tready = 1'b1;
        tick();
        tick();
        check("inv_full_stays_empty", {31'd0, m_if.tvalid}, 32'd0);

        // Invalidate in BUSY with a beat accepted the same cycle: both dropped
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h33;
        tick();
        s_if.tdata = 8'h44;
        invalidate = 1'b1;
        tick();
        invalidate  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        check("inv_busy_mvalid", {31'd0, m_if.tvalid}, 32'd0);
        tick();
        check("inv_busy_stays_empty", {31'd0, m_if.tvalid}, 32'd0);
        check("final_q_empty", exp_q.size(), 32'd0);

`ifdef AXIS_SKID_SLICE_PERF_EN
        // Stall counter: 4-bit, saturating, untouched by invalidate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_rst", {28'd0, stall_cnt}, 32'd0);
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h07;
        tick();
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("perf_cnt_5", {28'd0, stall_cnt}, 32'd5);
        for (int i = 0; i < 15; i++) tick();
        check("perf_cnt_sat", {28'd0, stall_cnt}, 32'd15);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        tick();
        check("perf_inv_keeps", {28'd0, stall_cnt}, 32'd15);
        m_if.tready = 1'b1;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
